alu_mul_seq: RTL and testbench

- Iterative unsigned shift-add multiplier controller that borrows the shared 32-bit ALU (ADD op) to form a 32x32 -> low-32 product.
- Sits beside the ALU. Requests the ALU each cycle it needs an add and waits for an external grant, so the pipeline keeps priority.
- Multiplicand shifting and multiplier scanning happen in internal registers. Only the accumulate goes through the ALU.

---
 rtl/alu_mul_seq_if.sv | 30 +++
 rtl/alu_mul_seq.sv | 65 ++++++
 tb/tb_alu_mul_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/alu_mul_seq_if.sv
// Bundle of the multiplier's command/result signals and its shared-ALU port.
//   start/a/b      : operation request (sampled only while idle)
//   busy/done/p    : status and registered low-32 product
//   alu_req/alu_gnt: ALU borrow handshake, add consumed on req && gnt
//   alu_a/alu_b/alu_aluc -> ALU operands and function, alu_r <- ALU result
// master = the multiplier, slave = the surrounding pipeline/ALU side.
interface alu_mul_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] p;
  logic        alu_req;
  logic        alu_gnt;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] alu_r;

  modport master (
    input  start, a, b, alu_gnt, alu_r,
    output busy, done, p, alu_req, alu_a, alu_b, alu_aluc
  );

  modport slave (
    output start, a, b, alu_gnt, alu_r,
    input  busy, done, p, alu_req, alu_a, alu_b, alu_aluc
  );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier (32x32 -> low 32) that borrows the
// shared ALU for every accumulate and otherwise shifts internally.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active high
//   bus  : alu_mul_seq_if.master (start/a/b in, busy/done/p out, ALU borrow port)
module alu_mul_seq #(
  parameter logic [3:0] ALU_ADD = 4'b0000
) (
  input  logic          clk,
  input  logic          rst,
  alu_mul_seq_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [31:0] mc, mp, acc, p_q;
  logic        add_req;

  // Request is a function of registered state only; grant never feeds back
  // into it. mp[0]==1 already implies mp!=0.
  assign add_req = (state == RUN) && mp[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      mc    <= '0;
      mp    <= '0;
      acc   <= '0;
      p_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          mc    <= bus.a;
          mp    <= bus.b;
          acc   <= '0;
          state <= RUN;
        end
        RUN: begin
          if (mp == '0) begin
            p_q   <= acc;
            state <= DONE;
          end else if (!mp[0] || bus.alu_gnt) begin
            // a denied add freezes everything so the request repeats next cycle
            if (mp[0]) acc <= bus.alu_r;
            mc <= mc << 1;
            mp <= mp >> 1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = (state == DONE);
  assign bus.p        = p_q;
  assign bus.alu_req  = add_req;
  assign bus.alu_a    = add_req ? acc : 32'd0;
  assign bus.alu_b    = add_req ? mc  : 32'd0;
  assign bus.alu_aluc = add_req ? ALU_ADD : 4'b0000;
endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;
  logic clk = 1'b0;
  logic rst;
  alu_mul_seq_if bus();

  alu_mul_seq dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // the shared ALU performing ADD
  assign bus.alu_r = bus.alu_a + bus.alu_b;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: an operation scans bit positions i = 0.. of b; position i
  // takes one cycle, plus one per denied add when bit i is set. Once no set bits
  // remain at or above i, one more cycle then a done cycle with p = a*b.
  int          m_st = 0; // 0 idle, 1 scanning, 2 done cycle
  int          m_i  = 0;
  logic [31:0] m_a = '0, m_b = '0, m_p = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_st = 0;
      m_p  = '0;
    end else begin
      case (m_st)
        0: if (bus.start) begin m_st = 1; m_a = bus.a; m_b = bus.b; m_i = 0; end
        1: if ((m_b >> m_i) == 32'd0) begin m_st = 2; m_p = m_a * m_b; end
           else if (!m_b[m_i] || bus.alu_gnt) m_i++;
        default: m_st = 0;
      endcase
    end
  end

  // compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic        e_req;
    logic [63:0] mask;
    logic [31:0] e_aa, e_ab;
    if (chk_en) begin
      e_req = (m_st == 1) && ((m_b >> m_i) != 32'd0) && m_b[m_i];
      mask  = (64'd1 << m_i) - 64'd1;
      e_aa  = e_req ? m_a * (m_b & mask[31:0]) : 32'd0;
      e_ab  = e_req ? m_a << m_i : 32'd0;
      check("busy",     {63'd0, bus.busy},    {63'd0, m_st != 0});
      check("done",     {63'd0, bus.done},    {63'd0, m_st == 2});
      check("alu_req",  {63'd0, bus.alu_req}, {63'd0, e_req});
      check("alu_a",    {32'd0, bus.alu_a},   {32'd0, e_aa});
      check("alu_b",    {32'd0, bus.alu_b},   {32'd0, e_ab});
      check("alu_aluc", {60'd0, bus.alu_aluc}, 64'd0);
      check("p",        {32'd0, bus.p},       {32'd0, m_p});
    end
  end

  // Start an op from idle (start edge = cycle 0), deny grant in cycles
  // [off_lo, off_hi], optionally hammer start with junk; report done cycle
  // and a bitmap of cycles where alu_req was seen.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v,
                        input int off_lo, input int off_hi, input bit spam,
                        output int dcyc, output logic [63:0] reqm);
    dcyc = -1;
    reqm = '0;
    bus.a = ta; bus.b = tb_v; bus.start = 1'b1; bus.alu_gnt = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c <= 60 && dcyc < 0; c++) begin
      bus.alu_gnt = !(c >= off_lo && c <= off_hi);
      if (spam) begin bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom; end
      @(negedge clk);
      if (bus.alu_req) reqm[c] = 1'b1;
      if (bus.done) dcyc = c;
      @(posedge clk); #1;
      bus.start = 1'b0;
    end
    if (dcyc < 0) begin
      n_chk++; n_err++;
      $display("FAIL timeout: no done within 60 cycles for a=%0h b=%0h", ta, tb_v);
    end
    bus.alu_gnt = 1'b1;
  endtask

  initial begin
    int          dc;
    logic [63:0] rm;
    rst = 1'b1; bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.alu_gnt = 1'b0;
    @(posedge clk); chk_en = 1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {63'd0, bus.busy}, 64'd0);
    check("rst_req",  {63'd0, bus.alu_req}, 64'd0);
    check("rst_p",    {32'd0, bus.p}, 64'd0);
    @(posedge clk); #1;

    // 1: 7*6
    run_op(32'd7, 32'd6, 0, -1, 1'b0, dc, rm);
    check("s1_done_cyc", dc, 5);
    check("s1_req_map", rm, 64'hC);
    check("s1_p", {32'd0, bus.p}, 64'd42);

    // 2: b = 0
    run_op(32'h1234, 32'd0, 0, -1, 1'b0, dc, rm);
    check("s2_done_cyc", dc, 2);
    check("s2_req_map", rm, 64'd0);
    check("s2_p", {32'd0, bus.p}, 64'd0);

    // 3: all ones
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1'b0, dc, rm);
    check("s3_done_cyc", dc, 34);
    check("s3_req_map", rm, 64'h1_FFFF_FFFE);
    check("s3_p", {32'd0, bus.p}, 64'd1);

    // 4: grant withheld cycles 2..4 during first add
    run_op(32'd7, 32'd6, 2, 4, 1'b0, dc, rm);
    check("s4_done_cyc", dc, 8);
    check("s4_req_map", rm, 64'h7C);
    check("s4_p", {32'd0, bus.p}, 64'd42);

    // 5: reset mid-run
    bus.a = 32'd5; bus.b = 32'hFF; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("s5_busy", {63'd0, bus.busy}, 64'd0);
    check("s5_p",    {32'd0, bus.p}, 64'd0);
    repeat (5) @(posedge clk);
    #1;
    run_op(32'd3, 32'd5, 0, -1, 1'b0, dc, rm);
    check("s5_done_cyc", dc, 5);
    check("s5_p2", {32'd0, bus.p}, 64'd15);

    // 6: start hammered during RUN and DONE
    run_op(32'd7, 32'd6, 0, -1, 1'b1, dc, rm);
    check("s6_done_cyc", dc, 5);
    @(negedge clk);
    check("s6_busy", {63'd0, bus.busy}, 64'd0);
    check("s6_p", {32'd0, bus.p}, 64'd42);
    @(posedge clk); #1;

    // random traffic; the compare process checks every cycle
    for (int k = 0; k < 4000; k++) begin
      rst         = ($urandom_range(0, 299) == 0);
      bus.start   = ($urandom_range(0, 3) == 0);
      bus.a       = $urandom;
      bus.b       = $urandom >> $urandom_range(0, 31);
      bus.alu_gnt = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    rst = 1'b0; bus.start = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
